// File: rtl/tlul_ahb_pkg.sv
// Shared types and constants for the TL-UL to AHB-Lite write bridge.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package tlul_ahb_pkg;

  // TL-UL A-channel opcodes the bridge recognises
  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    GET         = 3'd4
  } tl_a_op_e;

  // TL-UL D-channel response opcodes
  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  // AHB-Lite transfer types
  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_e;

  // Bridge sequencing: accept, AHB address phase, AHB data phase, TL response
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } bridge_state_e;

  // The only transfer size the slave supports: one 32-bit word
  localparam logic [2:0] HSIZE_WORD   = 3'b010;
  localparam logic [1:0] TL_SIZE_WORD = 2'd2;
  localparam logic [3:0] MASK_FULL    = 4'hF;

endpackage

// File: rtl/tlul_req_check.sv
// Classifies a TL-UL A request as legal (full aligned word write) or illegal.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller samples the result on its own handshake.
module tlul_req_check
  import tlul_ahb_pkg::*;
(
  input  logic [2:0] opcode_i,
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  input  logic [3:0] mask_i,
  output logic       illegal_o,
  output logic [2:0] rsp_op_o
);

  logic is_put;
  logic word_ok;

  // The slave has no byte strobes, so only full aligned words may pass.
  // PutPartialData is tolerated only when it is effectively a full write.
  assign is_put    = (opcode_i == PUT_FULL) || (opcode_i == PUT_PARTIAL);
  assign word_ok   = (size_i == TL_SIZE_WORD) && (addr_lo_i == 2'b00) &&
                     (mask_i == MASK_FULL);
  assign illegal_o = !(is_put && word_ok);

  // A rejected Get still expects a data-carrying response opcode.
  assign rsp_op_o  = (opcode_i == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;

endmodule

// File: rtl/tlul_ahb_write_bridge.sv
// Converts one TL-UL word write into one AHB-Lite write; illegal requests are answered locally.
// Latency: accept at edge N, ADDR in N+1, DATA in N+2, response valid in N+3 (no stalls).
// Backpressure: HREADY low stalls ADDR/DATA; d_ready low stalls RESP; a_ready only in IDLE.
// Optional: define TLUL_AHB_BRIDGE_TIMEOUT_EN to abort a phase after TIMEOUT_CYCLES HREADY-low cycles.
module tlul_ahb_write_bridge
  import tlul_ahb_pkg::*;
#(
  parameter int SRC_W          = 8,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  // TL-UL A channel
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [1:0]        a_size,
  input  logic [SRC_W-1:0]  a_source,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [31:0]       a_data,
  input  logic [3:0]        a_mask,
  // TL-UL D channel
  output logic              d_valid,
  input  logic              d_ready,
  output logic [2:0]        d_opcode,
  output logic [SRC_W-1:0]  d_source,
  output logic              d_error,
  // AHB-Lite master
  output logic              HSEL,
  output logic              HWRITE,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic [ADDR_W-1:0] HADDR,
  output logic [31:0]       HWDATA,
  input  logic              HREADY
);

  bridge_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic [2:0]        dop_q, dop_d;
  logic              derr_q, derr_d;

  logic              chk_illegal;
  logic [2:0]        chk_op;
  logic              tmo_hit;

  tlul_req_check u_req_check (
    .opcode_i  (a_opcode),
    .size_i    (a_size),
    .addr_lo_i (a_address[1:0]),
    .mask_i    (a_mask),
    .illegal_o (chk_illegal),
    .rsp_op_o  (chk_op)
  );

`ifdef TLUL_AHB_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             stalled;

  assign stalled = ((state_q == ST_ADDR) || (state_q == ST_DATA)) && !HREADY;
  // Last allowed stall cycle: the edge that would make the count reach the limit aborts.
  assign tmo_hit = stalled && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Stall counter: restarts on every state change, counts HREADY-low cycles in a phase
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (stalled) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout;

  // Without the watchdog the bridge waits on HREADY forever.
  assign tmo_hit        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // State and transaction context registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      src_q   <= '0;
      dop_q   <= '0;
      derr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      src_q   <= src_d;
      dop_q   <= dop_d;
      derr_q  <= derr_d;
    end
  end

  // Next-state and output decode; outputs are idle unless the state drives them
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    src_d    = src_q;
    dop_d    = dop_q;
    derr_d   = derr_q;

    a_ready  = 1'b0;
    d_valid  = 1'b0;
    d_opcode = '0;
    d_source = '0;
    d_error  = 1'b0;
    HSEL     = 1'b0;
    HWRITE   = 1'b0;
    HTRANS   = HT_IDLE;
    HSIZE    = '0;
    HADDR    = '0;
    HWDATA   = '0;

    unique case (state_q)
      ST_IDLE: begin
        a_ready = !HRESET;
        if (a_valid && a_ready) begin
          addr_d = a_address;
          data_d = a_data;
          src_d  = a_source;
          dop_d  = chk_op;
          derr_d = chk_illegal;
          // Illegal requests skip the bus entirely and are answered locally
          state_d = chk_illegal ? ST_RESP : ST_ADDR;
        end
      end

      ST_ADDR: begin
        HSEL   = 1'b1;
        HWRITE = 1'b1;
        HTRANS = HT_NONSEQ;
        HSIZE  = HSIZE_WORD;
        HADDR  = addr_q;
        if (HREADY) begin
          state_d = ST_DATA;
        end else if (tmo_hit) begin
          state_d = ST_RESP;
          derr_d  = 1'b1;
          dop_d   = ACCESS_ACK;
        end
      end

      ST_DATA: begin
        HWDATA = data_q;
        if (HREADY) begin
          state_d = ST_RESP;
          derr_d  = 1'b0;
          dop_d   = ACCESS_ACK;
        end else if (tmo_hit) begin
          state_d = ST_RESP;
          derr_d  = 1'b1;
          dop_d   = ACCESS_ACK;
        end
      end

      ST_RESP: begin
        d_valid  = 1'b1;
        d_source = src_q;
        d_opcode = dop_q;
        d_error  = derr_q;
        if (d_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
